sp_core: RTL and testbench
==========================

# sp_core

Single-issue simple processor core driven one instruction per cycle by an instruction source over the `in_valid`/`inst`/`inst_addr` interface. Each accepted instruction executes in one cycle:

- register write-back, data-memory write and PC update all occur at the accepting clock edge;
- `out_valid` reports completion one cycle later.

The core owns the 32-entry register file `r`, probed hierarchically by benches. It drives a separate data-memory block through a combinational-read, synchronous-write port.

## Interface
- `MEM_AW`, 12, data-memory word-address width (4096 words)
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `inst` is valid this cycle
- `inst`  in  32  instruction fetched from `inst_addr`
- `out_valid`  out  1  previous-cycle instruction has completed
- `inst_addr`  out  32  byte address of the next instruction to fetch (PC)
- `mem_wen`  out  1  data-memory write enable
- `mem_addr`  out  MEM_AW  data-memory word address
- `mem_din`  out  32  write data to memory
- `mem_dout`  in  32  combinational read data from memory

## Operation
- **Fields:** `op`=inst[31:26], `rs`=[25:21], `rt`=[20:16], `rd`=[15:11], `shamt`=[10:6], `func`=[5:0], `imm`=[15:0], `addr`=[25:0].
- **Immediates:**
  - `zimm` = zero-extended `imm`, used by andi and ori.
  - `simm` = sign-extended `imm`, used by all other I-type instructions.
- **R-type (op 0):** write `r[rd]`:
  - func 0 and: `rs&rt`
  - func 1 or: `rs|rt`
  - func 2 add: `rs+rt`
  - func 3 sub: `rs-rt`
  - func 4 slt: signed `rs<rt` gives 1, else 0
  - func 5 sll: `r[rs]<<shamt`
  - func 6 nor: `~(rs|rt)`
  - func 7 jr: no write
- **I-type:**
  - op1 andi: `r[rt]=r[rs]&zimm`
  - op2 ori: `r[rt]=r[rs]|zimm`
  - op3 addi: `r[rt]=r[rs]+simm`
  - op4 subi: `r[rt]=r[rs]-simm`
  - op5 lw: `r[rt]=mem_dout`
  - op6 sw: `mem_wen=1`, `mem_din=r[rt]`
  - op9 lui: `r[rt]={imm,16'h0}`
- **Memory address:** lw and sw use word address `(r[rs]+simm)[MEM_AW-1:0]`. It is a word index, not a byte address, and is truncated with no exception.
- **Next PC:**
  - beq (op7) taken when `r[rs]==r[rt]`; bne (op8) taken when `r[rs]!=r[rt]`. Taken target: `pc+4+(simm<<2)`.
  - j (op10): `{pc[31:28],addr,2'b00}`.
  - jal (op11): same target as j, and also `r[31]=pc+4`.
  - jr: `r[31]`, the value before this edge.
  - Otherwise: `pc+4`.
- **Register file:**
  - All arithmetic is 32-bit with wrap-around; no overflow flags.
  - `r[0]` is an ordinary writable register, not hardwired to zero.
  - Operands are read from the current contents of `r`, so an instruction always sees every earlier instruction's result; no hazards exist.
- **Unknown encodings:** undefined op/func values are no-ops; PC advances by 4.
- **Idle cycles:**
  - `in_valid=0`: no register write, `mem_wen=0`, PC holds, `inst` ignored (may be X).
  - `mem_wen` and `mem_addr` are combinational from `inst`/`r`, and `mem_wen` is gated by `in_valid`.

## Timing
- **Reset (async):**
  - `inst_addr=0`, `out_valid=0`, all `r[i]=0`.
  - `mem_wen=0`, because it is gated by `in_valid`, which is low during reset.
  - Reset mid-program aborts the in-flight instruction; any write on that edge is lost.
- **Edge accepting instruction N** (`in_valid=1`) updates, all at the same edge:
  - the register write;
  - `inst_addr` to next PC;
  - the memory write;
  - `out_valid` to 1.
- **Latency and throughput:**
  - Latency is 1 cycle, from `in_valid` sampled to `out_valid` high.
  - Throughput is 1 instruction/cycle.
  - `inst_addr` is registered and valid throughout the cycle after acceptance, so the source can fetch instruction N+1 combinationally.
- **`out_valid`:**
  - It is a registered copy of `in_valid`.
  - With continuous `in_valid` it stays high with no gaps.
  - It drops one cycle after `in_valid` drops.
- **Observability:** `r` is stable and reflects instruction N for the full cycle in which `out_valid` reports it.

## Test plan
- **Reset:** assert `rst_n=0` mid-cycle with no clock running -> `out_valid=0`, `inst_addr=0`, all 32 registers read 0 immediately.
- **ALU chain:**
  - Program: addi r1=r0+5, addi r2=r0-3, add r3=r1+r2, slt r4=r2<r1, nor r5=r0|r0, sll r6=r1<<4.
  - Required: r3=2, r4=1, r5=0xFFFFFFFF, r6=80.
  - `out_valid` high from cycle 2 with no gaps; `inst_addr` steps 4, 8, …, 24.
- **Memory:**
  - Program: addi r1=100, sw r1→mem[r0+7], lw r2←mem[r0+7].
  - Required: `mem_wen` pulses only on the sw cycle with `mem_addr=7`; r2=100.
  - Also: lw from address 4095+1 wraps to mem[0].
- **Branches:**
  - beq with equal operands and imm=-2 at pc=40 -> `inst_addr=36`.
  - bne with equal operands -> `inst_addr=pc+4`.
  - andi with imm 0x8000 -> zero-extended result.
- **Jumps:**
  - jal addr=0x10 at pc=8 -> r31=12, `inst_addr=0x40`.
  - Subsequent jr -> `inst_addr=12`.
  - lui r7,0xABCD -> r7=0xABCD0000.
- **Handshake gaps:**
  - Drop `in_valid` for 3 cycles with `inst=X` -> PC and registers unchanged, `out_valid` low one cycle after the drop.
  - Resume -> execution continues correctly.
  - Reset asserted mid-stream -> all state returns to 0.

Source files
------------

// File: rtl/sp_core.sv
// Single-issue core: one instruction per accepted cycle, all architectural state
// (register file, PC, data-memory write) commits on the accepting edge.
module sp_core #(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       inst,
  output logic              out_valid,
  output logic [31:0]       inst_addr,
  output logic              mem_wen,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [5:0] {
    OP_R    = 6'd0,  OP_ANDI = 6'd1, OP_ORI = 6'd2, OP_ADDI = 6'd3,
    OP_SUBI = 6'd4,  OP_LW   = 6'd5, OP_SW  = 6'd6, OP_BEQ  = 6'd7,
    OP_BNE  = 6'd8,  OP_LUI  = 6'd9, OP_J   = 6'd10, OP_JAL = 6'd11
  } op_e;

  typedef enum logic [5:0] {
    FN_AND = 6'd0, FN_OR  = 6'd1, FN_ADD = 6'd2, FN_SUB = 6'd3,
    FN_SLT = 6'd4, FN_SLL = 6'd5, FN_NOR = 6'd6, FN_JR  = 6'd7
  } fn_e;

  // Architectural register file; name kept short so benches can probe it.
  logic [31:0] r [32];
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;

  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [31:0] rs_v, rt_v, zimm, simm, ea, pc_inc;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data, pc_nxt;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign shamt = inst[10:6];
  assign func  = inst[5:0];
  assign imm   = inst[15:0];
  assign jaddr = inst[25:0];

  always_comb begin
    rs_v    = r[rs];
    rt_v    = r[rt];
    zimm    = {16'h0, imm};
    simm    = {{16{imm[15]}}, imm};
    ea      = rs_v + simm;
    pc_inc  = pc_q + 32'd4;
    wr_en   = 1'b0;
    wr_idx  = rt;
    wr_data = 32'h0;
    pc_nxt  = pc_inc;
    case (op)
      OP_R: begin
        wr_en  = 1'b1;
        wr_idx = rd;
        case (func)
          FN_AND:  wr_data = rs_v & rt_v;
          FN_OR:   wr_data = rs_v | rt_v;
          FN_ADD:  wr_data = rs_v + rt_v;
          FN_SUB:  wr_data = rs_v - rt_v;
          FN_SLT:  wr_data = {31'h0, $signed(rs_v) < $signed(rt_v)};
          FN_SLL:  wr_data = rs_v << shamt;
          FN_NOR:  wr_data = ~(rs_v | rt_v);
          FN_JR: begin
            wr_en  = 1'b0;
            pc_nxt = r[31];
          end
          default: wr_en = 1'b0;
        endcase
      end
      OP_ANDI: begin wr_en = 1'b1; wr_data = rs_v & zimm;    end
      OP_ORI:  begin wr_en = 1'b1; wr_data = rs_v | zimm;    end
      OP_ADDI: begin wr_en = 1'b1; wr_data = rs_v + simm;    end
      OP_SUBI: begin wr_en = 1'b1; wr_data = rs_v - simm;    end
      OP_LW:   begin wr_en = 1'b1; wr_data = mem_dout;       end
      OP_LUI:  begin wr_en = 1'b1; wr_data = {imm, 16'h0};   end
      OP_BEQ:  if (rs_v == rt_v) pc_nxt = pc_inc + (simm << 2);
      OP_BNE:  if (rs_v != rt_v) pc_nxt = pc_inc + (simm << 2);
      OP_J:    pc_nxt = {pc_q[31:28], jaddr, 2'b00};
      OP_JAL: begin
        pc_nxt  = {pc_q[31:28], jaddr, 2'b00};
        wr_en   = 1'b1;
        wr_idx  = 5'd31;
        wr_data = pc_inc;
      end
      default: ;
    endcase
    // Idle cycles leave all state alone; inst may be X then.
    if (!in_valid) wr_en = 1'b0;
    pc_d        = in_valid ? pc_nxt : pc_q;
    out_valid_d = in_valid;
  end

  assign mem_wen   = in_valid && (op == OP_SW);
  assign mem_addr  = ea[MEM_AW-1:0];
  assign mem_din   = rt_v;
  assign inst_addr = pc_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= 32'h0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 32; i++) r[i] <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      if (wr_en) r[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sp_core.sv
// Scoreboard bench for sp_core: a behavioural ISA model predicts PC/registers per
// cycle, a monitor compares them after each edge; memory is a local array.
module tb_sp_core;
  localparam int AW = 12;

  logic          clk = 1'b0, clk_en = 1'b1;
  logic          rst_n, in_valid;
  logic [31:0]   inst;
  logic          out_valid, mem_wen;
  logic [31:0]   inst_addr, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  sp_core #(.MEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inst(inst),
    .out_valid(out_valid), .inst_addr(inst_addr), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  logic [31:0] tmem [4096];
  assign mem_dout = tmem[mem_addr];
  always @(posedge clk) if (mem_wen) tmem[mem_addr] <= mem_din;

  typedef struct packed {
    logic              vld;
    logic [31:0]       pc;
    logic [31:0][31:0] regs;
  } exp_t;

  exp_t              q[$];
  logic [31:0][31:0] mr;
  logic [31:0]       mpc;
  logic [31:0]       mmem [4096];
  int                n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] ej(input logic [5:0] op, input logic [25:0] a);
    return {op, a};
  endfunction

  // Reference semantics of one instruction on the model state.
  task automatic model_step(input logic [31:0] ins);
    int unsigned op = ins[31:26], fn = ins[5:0];
    logic [31:0] a = mr[ins[25:21]], b = mr[ins[20:16]];
    logic [31:0] si = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] zi = {16'h0, ins[15:0]};
    logic [31:0] nxt = mpc + 4;
    logic [AW-1:0] wa = AW'(a + si);
    case (op)
      0: case (fn)
           0: mr[ins[15:11]] = a & b;
           1: mr[ins[15:11]] = a | b;
           2: mr[ins[15:11]] = a + b;
           3: mr[ins[15:11]] = a - b;
           4: mr[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
           5: mr[ins[15:11]] = a << ins[10:6];
           6: mr[ins[15:11]] = ~(a | b);
           7: nxt = mr[31];
           default: ;
         endcase
      1: mr[ins[20:16]] = a & zi;
      2: mr[ins[20:16]] = a | zi;
      3: mr[ins[20:16]] = a + si;
      4: mr[ins[20:16]] = a - si;
      5: mr[ins[20:16]] = mmem[wa];
      6: mmem[wa] = b;
      7: if (a == b) nxt = mpc + 4 + si * 4;
      8: if (a != b) nxt = mpc + 4 + si * 4;
      9: mr[ins[20:16]] = {ins[15:0], 16'h0};
      10: nxt = {mpc[31:28], ins[25:0], 2'b00};
      11: begin nxt = {mpc[31:28], ins[25:0], 2'b00}; mr[31] = mpc + 4; end
      default: ;
    endcase
    mpc = nxt;
  endtask

  task automatic issue(input logic [31:0] ins);
    exp_t e;
    logic [31:0] ea;
    @(negedge clk);
    ea = mr[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
    in_valid = 1'b1;
    inst = ins;
    #1;
    chk("mem_wen", 32'(mem_wen), (ins[31:26] == 6'd6) ? 32'd1 : 32'd0);
    if (ins[31:26] == 6'd6) begin
      chk("mem_addr", 32'(mem_addr), 32'(ea[AW-1:0]));
      chk("mem_din", mem_din, mr[ins[20:16]]);
    end
    model_step(ins);
    e.vld = 1'b1; e.pc = mpc; e.regs = mr;
    q.push_back(e);
  endtask

  task automatic idle();
    exp_t e;
    @(negedge clk);
    in_valid = 1'b0;
    inst = 'x;
    #1;
    chk("idle_mem_wen", 32'(mem_wen), 32'd0);
    e.vld = 1'b0; e.pc = mpc; e.regs = mr;
    q.push_back(e);
  endtask

  // Called just after a negedge: any instruction presented this cycle is aborted.
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    mr = '0;
    mpc = 32'h0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inst_addr", inst_addr, 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("rst_r%0d", i), dut.r[i], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: each entry pushed before an edge is compared right after that edge.
  initial begin
    exp_t e;
    int bad;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.vld));
        chk("inst_addr", inst_addr, e.pc);
        bad = -1;
        for (int i = 31; i >= 0; i--) if (dut.r[i] !== e.regs[i]) bad = i;
        n_checks++;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL regs: r%0d got %h expected %h", bad, dut.r[bad], e.regs[bad]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    logic [31:0] ins;
    for (int i = 0; i < 4096; i++) begin tmem[i] = 32'h0; mmem[i] = 32'h0; end
    mr = '0; mpc = 32'h0;
    rst_n = 1'b0; in_valid = 1'b0; inst = 32'h0;
    #22;
    @(negedge clk);
    rst_n = 1'b1;

    // ALU chain
    issue(ei(3, 0, 1, 16'd5));
    issue(ei(3, 0, 2, 16'hFFFD));
    issue(er(1, 2, 3, 0, 2));
    issue(er(2, 1, 4, 0, 4));
    issue(er(0, 0, 5, 0, 6));
    issue(er(1, 0, 6, 4, 5));
    idle();
    chk("alu_r3", dut.r[3], 32'd2);
    chk("alu_r4", dut.r[4], 32'd1);
    chk("alu_r5", dut.r[5], 32'hFFFF_FFFF);
    chk("alu_r6", dut.r[6], 32'd80);
    chk("alu_pc", inst_addr, 32'd24);

    // Memory, including address wrap
    issue(ei(3, 0, 1, 16'd100));
    issue(ei(6, 0, 1, 16'd7));
    issue(ei(5, 0, 2, 16'd7));
    issue(ei(3, 0, 1, 16'h0FFF));
    issue(ei(3, 0, 9, 16'd77));
    issue(ei(6, 0, 9, 16'd0));
    issue(ei(5, 1, 3, 16'd1));
    idle();
    chk("lw_r2", dut.r[2], 32'd100);
    chk("lw_wrap_r3", dut.r[3], 32'd77);

    // Branches
    issue(ej(10, 26'd10));
    issue(ei(7, 0, 0, 16'hFFFE));
    idle();
    chk("beq_pc", inst_addr, 32'd36);
    issue(ei(8, 0, 0, 16'd5));
    idle();
    chk("bne_pc", inst_addr, 32'd40);
    issue(ei(3, 0, 9, 16'hFFFF));
    issue(ei(1, 9, 8, 16'h8000));
    idle();
    chk("andi_r8", dut.r[8], 32'h0000_8000);

    // Jumps
    issue(ej(10, 26'd2));
    issue(ej(11, 26'h10));
    idle();
    chk("jal_r31", dut.r[31], 32'd12);
    chk("jal_pc", inst_addr, 32'h40);
    issue(er(31, 0, 0, 0, 7));
    idle();
    chk("jr_pc", inst_addr, 32'd12);
    issue(ei(9, 0, 7, 16'hABCD));
    idle();
    chk("lui_r7", dut.r[7], 32'hABCD_0000);

    // Handshake gap then resume
    issue(ei(3, 7, 10, 16'd1));
    idle(); idle(); idle();
    issue(er(10, 7, 11, 0, 3));
    idle();
    chk("resume_r11", dut.r[11], 32'd1);

    // Reset with the clock stopped
    @(negedge clk);
    clk_en = 1'b0;
    #20;
    clk_en = 1'b1;
    do_reset();

    // Random program with gaps and one mid-stream reset
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) idle();
      else if (n == 200) begin
        issue(ei(3, 0, 1, 16'd9));
        do_reset();
      end else begin
        op = 6'($urandom_range(0, 12));
        if (op == 0)
          ins = er(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom_range(0, 8)));
        else if (op == 10 || op == 11)
          ins = ej(op, 26'($urandom));
        else
          ins = ei(op, 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                   16'($urandom));
        issue(ins);
      end
    end
    idle();
    idle();
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
